lgwin: RTL and testbench

Neighbourhood window generator for the FHP lattice-gas pipeline. It accepts a raster-ordered stream of 8-bit cells for one W×H frame and emits, for every cell in the same order, the 3×3 neighbourhood `c0..c8` plus the row-parity bit `x`. These are exactly the operands the propagation stage consumes. It sits between the frame/state memory reader and the propagation stage, and is the producer end of that stage's operand interface.

---
 rtl/lg_pkg.sv | 24 ++
 rtl/lgwin_linebuf.sv | 33 +++
 rtl/lgwin.sv | 250 +++++++++++++++++++++++++
 tb/tb_lgwin.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lg_pkg.sv
// Shared types and constants for the lattice-gas window generator.
package lg_pkg;

  typedef logic [7:0] cell_t;

  // Window slot indices, row-major; C4 is the centre cell.
  localparam int C0 = 0;
  localparam int C1 = 1;
  localparam int C2 = 2;
  localparam int C3 = 3;
  localparam int C4 = 4;
  localparam int C5 = 5;
  localparam int C6 = 6;
  localparam int C7 = 7;
  localparam int C8 = 8;
  localparam int NWIN = 9;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lgwin_state_t;

endpackage

// File: rtl/lgwin_linebuf.sv
// Cell delay line with a shift enable; bridges the window rows in the chain.
// DEPTH = 0 degenerates to a wire, which is what a 3-wide frame needs.
module lgwin_linebuf
  import lg_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_shift,
  input  cell_t i_cell,
  output cell_t o_cell
);

  if (DEPTH == 0) begin : g_wire
    assign o_cell = i_cell;
  end else begin : g_regs
    cell_t r_mem [DEPTH];

    // Shift one cell along the line on each enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_shift) begin
        r_mem[0] <= i_cell;
        for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
      end
    end

    assign o_cell = r_mem[DEPTH-1];
  end

endmodule

// File: rtl/lgwin.sv
// 3x3 neighbourhood window generator for the FHP propagation stage.
//
// state | meaning
// FILL  | priming the chain with the first W+1 cells; no windows produced
// RUN   | every accepted cell produces one window (centre = n-W-1)
// DRAIN | input closed; zeros pushed in to flush the last W+1 windows
//
// Chain order (newest first): c8 c7 c6 [lb_b] c5 c4 c3 [lb_a] c2 c1 c0.
// The window is computed from the post-shift chain values and masked at the
// frame edges as it is registered, so stale cells never reach the outputs.
module lgwin
  import lg_pkg::*;
#(
  parameter int W = 64,
  parameter int H = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_cell,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] c0,
  output logic [7:0] c1,
  output logic [7:0] c2,
  output logic [7:0] c3,
  output logic [7:0] c4,
  output logic [7:0] c5,
  output logic [7:0] c6,
  output logic [7:0] c7,
  output logic [7:0] c8,
  output logic       x,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int NW = $clog2(W * H + 1);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int LB_DEPTH = W - 3;

  localparam logic [NW-1:0] N_FILL_END = NW'(W);
  localparam logic [NW-1:0] N_LAST_IN  = NW'(W * H - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(H - 1);

  lgwin_state_t  r_state;
  logic [NW-1:0] r_n;
  logic [CW-1:0] r_ocol;
  logic [RW-1:0] r_orow;

  cell_t r_chain [NWIN];
  cell_t r_win   [NWIN];
  logic  r_x;
  logic  r_last;
  logic  r_out_valid;

  cell_t w_nxt [NWIN];
  cell_t w_win [NWIN];
  cell_t w_shift_in;
  cell_t w_lba_out;
  cell_t w_lbb_out;
  logic  w_out_free;
  logic  w_in_xfer;
  logic  w_shift;
  logic  w_load;
  logic  w_top;
  logic  w_bot;
  logic  w_left;
  logic  w_right;
  logic  w_last_pos;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;

  // Input handshake and chain/window advance per state.
  always_comb begin
    in_ready   = 1'b0;
    w_shift    = 1'b0;
    w_load     = 1'b0;
    w_shift_in = in_cell;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        w_shift  = w_in_xfer;
      end
      RUN: begin
        in_ready = w_out_free;
        w_shift  = w_in_xfer;
        w_load   = w_in_xfer;
      end
      DRAIN: begin
        w_shift_in = '0;
        w_shift    = w_out_free;
        w_load     = w_out_free;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  lgwin_linebuf #(.DEPTH(LB_DEPTH)) u_lb_b (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_shift),
    .i_cell  (r_chain[C6]),
    .o_cell  (w_lbb_out)
  );

  lgwin_linebuf #(.DEPTH(LB_DEPTH)) u_lb_a (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_shift),
    .i_cell  (r_chain[C3]),
    .o_cell  (w_lba_out)
  );

  // Chain contents after the pending shift.
  always_comb begin
    w_nxt[C8] = w_shift_in;
    w_nxt[C7] = r_chain[C8];
    w_nxt[C6] = r_chain[C7];
    w_nxt[C5] = w_lbb_out;
    w_nxt[C4] = r_chain[C5];
    w_nxt[C3] = r_chain[C4];
    w_nxt[C2] = w_lba_out;
    w_nxt[C1] = r_chain[C2];
    w_nxt[C0] = r_chain[C1];
  end

  assign w_top      = (r_orow == '0);
  assign w_bot      = (r_orow == ROW_LAST);
  assign w_left     = (r_ocol == '0);
  assign w_right    = (r_ocol == COL_LAST);
  assign w_last_pos = w_bot && w_right;

  // Zero the neighbours that fall outside the frame.
  always_comb begin
    for (int i = 0; i < NWIN; i++) w_win[i] = w_nxt[i];
    if (w_top) begin
      w_win[C0] = '0;
      w_win[C1] = '0;
      w_win[C2] = '0;
    end
    if (w_bot) begin
      w_win[C6] = '0;
      w_win[C7] = '0;
      w_win[C8] = '0;
    end
    if (w_left) begin
      w_win[C0] = '0;
      w_win[C3] = '0;
      w_win[C6] = '0;
    end
    if (w_right) begin
      w_win[C2] = '0;
      w_win[C5] = '0;
      w_win[C8] = '0;
    end
  end

  // Delay chain window registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWIN; i++) r_chain[i] <= '0;
    end else if (w_shift) begin
      for (int i = 0; i < NWIN; i++) r_chain[i] <= w_nxt[i];
    end
  end

  // Sequencing FSM and input counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_n     <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_xfer) begin
            r_n <= r_n + 1'b1;
            if (r_n == N_FILL_END) r_state <= RUN;
          end
        end
        RUN: begin
          if (w_in_xfer) begin
            r_n <= r_n + 1'b1;
            if (r_n == N_LAST_IN) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_out_free && w_last_pos) begin
            r_state <= FILL;
            r_n     <= '0;
          end
        end
        default: begin
          r_state <= FILL;
          r_n     <= '0;
        end
      endcase
    end
  end

  // Centre position of the next window, raster order, wrapping per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_orow <= '0;
      r_ocol <= '0;
    end else if (w_load) begin
      if (w_right) begin
        r_ocol <= '0;
        r_orow <= w_bot ? '0 : r_orow + 1'b1;
      end else begin
        r_ocol <= r_ocol + 1'b1;
      end
    end
  end

  // Output register: load a new window or retire the held one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWIN; i++) r_win[i] <= '0;
      r_x         <= 1'b0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      for (int i = 0; i < NWIN; i++) r_win[i] <= w_win[i];
      r_x         <= r_orow[0];
      r_last      <= w_last_pos;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign c0        = r_win[C0];
  assign c1        = r_win[C1];
  assign c2        = r_win[C2];
  assign c3        = r_win[C3];
  assign c4        = r_win[C4];
  assign c5        = r_win[C5];
  assign c6        = r_win[C6];
  assign c7        = r_win[C7];
  assign c8        = r_win[C8];
  assign x         = r_x;
  assign out_last  = r_last;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_lgwin.sv
// Self-checking bench for lgwin on a 4x3 frame.
module tb_lgwin;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int FR = W * H;

  logic       clk;
  logic       rst;
  logic [7:0] in_cell;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] c0, c1, c2, c3, c4, c5, c6, c7, c8;
  logic       x;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  lgwin #(.W(W), .H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_cell   (in_cell),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c4        (c4),
    .c5        (c5),
    .c6        (c6),
    .c7        (c7),
    .c8        (c8),
    .x         (x),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  logic [7:0]  src [0:2*FR-1];
  logic [73:0] obs_q [$];
  logic [73:0] exp_q [$];
  int acc;
  int first_valid_acc;
  int drain_cnt;
  bit timed_out;

  // Observed window packed as {c0..c8, x, out_last}.
  function automatic logic [73:0] cur_win();
    return {c0, c1, c2, c3, c4, c5, c6, c7, c8, x, out_last};
  endfunction

  // Reference: neighbourhood of cell (r,c) in frame f, zero outside the frame.
  function automatic logic [73:0] model_win(input int f, input int r, input int c);
    logic [73:0] w;
    int rr, cc, k;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        k  = (dr + 1) * 3 + (dc + 1);
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          w[73 - 8*k -: 8] = src[f*FR + rr*W + cc];
      end
    end
    w[1] = r[0];
    w[0] = (r == H - 1) && (c == W - 1);
    return w;
  endfunction

  task automatic build_exp(input int nframes);
    exp_q.delete();
    for (int f = 0; f < nframes; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          exp_q.push_back(model_win(f, r, c));
  endtask

  task automatic load_src(input bit ramp);
    for (int i = 0; i < 2*FR; i++)
      src[i] = ramp ? 8'(i + 1) : 8'($urandom_range(255, 1));
  endtask

  task automatic start_test();
    acc = 0;
    first_valid_acc = -1;
    drain_cnt = 0;
    obs_q.delete();
  endtask

  // Drives the source stream and records every output transfer.
  task automatic run_stream(input int total_in, input int total_win, input int stop_acc,
                            input int valid_pct, input int ready_pct);
    int cyc;
    cyc = 0;
    timed_out = 0;
    while (1) begin
      if (stop_acc > 0 && acc >= stop_acc) break;
      if (stop_acc == 0 && acc >= total_in && obs_q.size() >= total_win) break;
      if (cyc >= 3000) begin
        timed_out = 1;
        break;
      end
      in_valid  = (acc < total_in) && (int'($urandom_range(99, 0)) < valid_pct);
      in_cell   = (acc < total_in) ? src[acc] : 8'h00;
      out_ready = int'($urandom_range(99, 0)) < ready_pct;
      @(negedge clk);
      if (out_valid && first_valid_acc < 0) first_valid_acc = acc;
      if (acc == total_in && !in_ready && out_valid) drain_cnt++;
      if (out_valid && out_ready) obs_q.push_back(cur_win());
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_cell = 8'h00;
    out_ready = 1'b1;
    #1;
    checks++;
    if (cur_win() !== 74'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs win=%h valid=%b expected 0/0", cur_win(), out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    start_test();
    load_src(1'b1);
    build_exp(1);
    run_stream(FR, FR, 0, 100, 100);
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL basic_timeout got %0d windows expected %0d", obs_q.size(), FR);
    end
    checks++;
    if (first_valid_acc !== W + 2) begin
      failures++;
      $display("FAIL basic_latency first valid after %0d inputs expected %0d", first_valid_acc, W + 2);
    end
    checks++;
    if (drain_cnt !== W + 1) begin
      failures++;
      $display("FAIL basic_drain in_ready low for %0d windows expected %0d", drain_cnt, W + 1);
    end
    checks++;
    if (obs_q.size() !== FR) begin
      failures++;
      $display("FAIL basic_count got %0d windows expected %0d", obs_q.size(), FR);
    end
    if (obs_q.size() == FR) begin
      checks++;
      if (obs_q[0] !== {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL basic_corner got %h", obs_q[0]);
      end
      checks++;
      if (obs_q[5] !== {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL basic_interior got %h", obs_q[5]);
      end
      checks++;
      if (obs_q[11] !== {8'd7, 8'd8, 8'd0, 8'd11, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL basic_last got %h", obs_q[11]);
      end
      for (int i = 0; i < FR; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL basic_win[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [73:0] snap;
    start_test();
    load_src(1'b0);
    build_exp(1);
    run_stream(FR, FR, 7, 100, 100);
    in_valid  = 1'b1;
    in_cell   = src[acc];
    out_ready = 1'b0;
    @(negedge clk);
    snap = cur_win();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall_start out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    for (int k = 1; k < 3; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || cur_win() !== snap) begin
        failures++;
        $display("FAIL bp_hold cycle %0d in_ready=%b valid=%b win=%h expected 0/1/%h",
                 k, in_ready, out_valid, cur_win(), snap);
      end
    end
    @(posedge clk);
    #1;
    run_stream(FR, FR, 0, 100, 100);
    checks++;
    if (timed_out || obs_q.size() !== FR) begin
      failures++;
      $display("FAIL bp_count got %0d windows expected %0d", obs_q.size(), FR);
    end
    for (int i = 0; i < FR && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_win[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_test();
    load_src(1'b0);
    run_stream(FR, FR, 7, 100, 100);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre out_valid=%b expected 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cur_win() !== 74'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_clear win=%h valid=%b in_ready=%b expected 0/0/1",
               cur_win(), out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_test();
    load_src(1'b0);
    build_exp(1);
    run_stream(FR, FR, 0, 100, 100);
    checks++;
    if (timed_out || obs_q.size() !== FR || first_valid_acc !== W + 2) begin
      failures++;
      $display("FAIL rmid_frame windows=%0d first_valid_acc=%0d expected %0d/%0d",
               obs_q.size(), first_valid_acc, FR, W + 2);
    end
    for (int i = 0; i < FR && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rmid_win[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    load_src(1'b0);
    build_exp(2);
    run_stream(2*FR, 2*FR, 0, 100, 100);
    checks++;
    if (timed_out || obs_q.size() !== 2*FR) begin
      failures++;
      $display("FAIL b2b_count got %0d windows expected %0d", obs_q.size(), 2*FR);
    end
    for (int i = 0; i < 2*FR && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i][0] !== ((i == FR - 1) || (i == 2*FR - 1))) begin
        failures++;
        $display("FAIL b2b_last[%0d] got %b", i, obs_q[i][0]);
      end
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_win[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int rep = 0; rep < 3; rep++) begin
      start_test();
      load_src(1'b0);
      build_exp(2);
      run_stream(2*FR, 2*FR, 0, 70, 60);
      checks++;
      if (timed_out || obs_q.size() !== 2*FR) begin
        failures++;
        $display("FAIL rand_count rep %0d got %0d windows expected %0d", rep, obs_q.size(), 2*FR);
      end
      for (int i = 0; i < 2*FR && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand_win rep %0d [%0d] got %h expected %h", rep, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
